mips_mc_control_ws: RTL
=======================

# mips_mc_control_ws

Multicycle MIPS control unit with memory wait states, extended opcode set and fault detection. It replaces the fixed-latency `control` FSM inside the `mips_mc` top level and drives the same datapath enables. It adds four things: a `mem_ready` handshake, a memory watchdog, an illegal-opcode trap and a retired-instruction counter.

## Interface
Parameters:
- `EXT_OPS`, default 1: 1 decodes bne/addi/j; 0 treats those opcodes as illegal.
- `MAX_WAIT`, default 15: consecutive not-ready cycles allowed per memory access; 0 disables the watchdog.
- `CNT_W`, default 16: width of the retired counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Op`  in  6  opcode from the instruction register.
- `Zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current read/write this cycle.
- `IorD`, `MemRead`, `MemWrite`, `MemToReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`, `PCSel`  out  1 each  datapath controls.
- `PCSource`, `ALUSrcB`, `ALUOp`  out  2 each  datapath selects.
- `state_o`  out  4  current state encoding.
- `err`  out  1  sticky fault indication.
- `retired`  out  `CNT_W`  count of completed instructions.

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- RTEX=6, RTWB=7, BEQEX=8, BNEEX=9, ADDIEX=10, ADDIWB=11
- JEX=12, ERROR=15

Transitions:
- FETCH → DECODE when `mem_ready`=1; otherwise stay.
- DECODE dispatches on `Op`:
  - 100011 or 101011 → MEMADR.
  - 000000 → RTEX.
  - 000100 → BEQEX.
  - 000101 → BNEEX (only if `EXT_OPS`).
  - 001000 → ADDIEX (only if `EXT_OPS`).
  - 000010 → JEX (only if `EXT_OPS`).
  - Any other opcode → ERROR.
- MEMADR → MEMRD for lw, MEMWR for sw.
- MEMRD → MEMWB on `mem_ready`.
- MEMWR → FETCH on `mem_ready`.
- MEMWB, RTWB, ADDIWB, BEQEX, BNEEX, JEX → FETCH.
- RTEX → RTWB. ADDIEX → ADDIWB.
- ERROR is held until reset.

Outputs are combinational from the state; every unlisted output is 0.
- FETCH: `MemRead`=1, `ALUSrcB`=01. `IRWrite`=`PCSel`=`mem_ready`.
- DECODE: `ALUSrcB`=11.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10.
- MEMRD: `IorD`=1, `MemRead`=1.
- MEMWB: `MemToReg`=1, `RegWrite`=1.
- MEMWR: `IorD`=1, `MemWrite`=1.
- RTEX: `ALUSrcA`=1, `ALUOp`=10.
- RTWB: `RegDst`=1, `RegWrite`=1.
- BEQEX: `ALUSrcA`=1, `ALUOp`=01, `PCSource`=01, `PCSel`=`Zero`.
- BNEEX: as BEQEX except `PCSel`=~`Zero`.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10.
- ADDIWB: `RegWrite`=1.
- JEX: `PCSource`=10, `PCSel`=1.
- ERROR: `err`=1.

Watchdog (wait states are FETCH, MEMRD, MEMWR):
- The wait counter clears on entry to any wait state and whenever `mem_ready`=1.
- It increments on each cycle in a wait state with `mem_ready`=0.
- If `mem_ready`=0 while the counter equals `MAX_WAIT`-1, the next state is ERROR instead of staying.

Retired counter:
- Increments by 1 on each edge that leaves MEMWB, RTWB, ADDIWB, BEQEX, BNEEX or JEX.
- Also increments on the edge that leaves MEMWR with `mem_ready`=1.
- Wraps modulo 2^`CNT_W`. It does not increment on entry to ERROR.

## Timing
- Reset asserted (`reset`=0): state=FETCH, wait counter=0, `retired`=0, `err`=0.
  - Outputs take their FETCH values immediately: `MemRead`=1, `ALUSrcB`=01, `IRWrite`/`PCSel` following `mem_ready`.
- Reset mid-instruction aborts it: no register write and no increment occur after assertion.
- Release is synchronous in effect: the first transition happens on the first rising edge with `reset`=1.
- Zero-wait latency:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq/bne 3; j 3.
  - Each not-ready cycle in a wait state adds 1 cycle.
- `PCSel` in BEQEX/BNEEX follows `Zero` within the same cycle.
- `mem_ready` is ignored outside wait states.
- `Op` is sampled only in DECODE.

## Test plan
- Zero-wait lw, `mem_ready` tied 1:
  - `state_o` 0,1,2,3,4,0.
  - `RegWrite`=`MemToReg`=1 only in cycle 5.
  - `retired` 0→1.
- sw with 3 not-ready cycles in MEMWR:
  - `MemWrite` held 4 cycles, then FETCH.
  - `retired` increments exactly once.
- beq with `Zero`=1 → `PCSel`=1, `PCSource`=01. bne with `Zero`=1 → `PCSel`=0. Each retires one.
- `Op`=111111 in DECODE → ERROR (`state_o`=15), `err`=1 and held, all controls 0. Assert `reset`=0 → FETCH, `err`=0.
- `MAX_WAIT`=4, `mem_ready` held 0 in FETCH → ERROR after exactly 4 cycles. With `MAX_WAIT`=0 → stays in FETCH indefinitely.
- `EXT_OPS`=0, `Op`=001000 → ERROR. `CNT_W`=2: five j instructions → `retired`=1 (wraps).

Source files
------------

// File: rtl/mips_mc_control_ws.sv
// Multicycle MIPS control FSM with memory wait states, a memory watchdog,
// an illegal-opcode trap and a retired-instruction counter.
module mips_mc_control_ws #(
    parameter bit          EXT_OPS  = 1'b1,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             PCSel,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state_o,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BEQEX  = 4'd8;
    localparam logic [3:0] S_BNEEX  = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JEX    = 4'd12;
    localparam logic [3:0] S_ERROR  = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam int unsigned      WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    logic [3:0]        state;
    logic [3:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_store;
    logic              in_wait;
    logic              wait_expired;
    logic              retire;

    assign in_wait      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign wait_expired = (MAX_WAIT != 0) && in_wait && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_BNE:       state_next = EXT_OPS ? S_BNEEX  : S_ERROR;
                    OP_ADDI:      state_next = EXT_OPS ? S_ADDIEX : S_ERROR;
                    OP_J:         state_next = EXT_OPS ? S_JEX    : S_ERROR;
                    default:      state_next = S_ERROR;
                endcase
            end
            S_MEMADR: state_next = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_RTEX:   state_next = S_RTWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_MEMWB, S_RTWB, S_ADDIWB, S_BEQEX, S_BNEEX, S_JEX: state_next = S_FETCH;
            default:  state_next = S_ERROR;
        endcase
        if (wait_expired) state_next = S_ERROR;
    end

    // A store only completes (and retires) once memory acknowledges the write.
    always_comb begin
        case (state)
            S_MEMWB, S_RTWB, S_ADDIWB, S_BEQEX, S_BNEEX, S_JEX: retire = 1'b1;
            S_MEMWR: retire = mem_ready;
            default: retire = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            is_store <= 1'b0;
            retired  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || mem_ready || !in_wait)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + WAIT_W'(1);
            // Op is only trusted in DECODE; remember lw vs sw for MEMADR.
            if (state == S_DECODE)
                is_store <= (Op == OP_SW);
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        IRWrite  = 1'b0;
        ALUSrcA  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        PCSel    = 1'b0;
        PCSource = 2'b00;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCSel   = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_RTEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RTWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCSel    = (state == S_BEQEX) ? Zero : ~Zero;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JEX: begin
                PCSource = 2'b10;
                PCSel    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = state;
    assign err     = (state == S_ERROR);

endmodule
